// File: rtl/klp32_mem_arbiter_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | klp32_mem_pkg : shared types and constants for the KLP32 arbiter      |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
package klp32_mem_pkg;
   localparam int MEM_LAT_MAX = 4;
   localparam int DEF_ADDR_W  = 32;
   localparam int DEF_DATA_W  = 32;

   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;
   typedef enum logic {OWN_IF = 1'b0, OWN_D = 1'b1} owner_t;
endpackage
`default_nettype wire

// File: rtl/klp32_mem_arbiter_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | klp32_mem_arbiter_if : fetch, data and memory buses of the arbiter    |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
interface klp32_mem_arbiter_if #(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
);
   logic                  i_if_req;
   logic [ADDR_W-1:0]     i_if_addr;
   logic                  o_if_gnt;
   logic                  o_if_rvalid;
   logic [DATA_W-1:0]     o_if_rdata;
   logic                  i_d_req;
   logic                  i_d_we;
   logic [ADDR_W-1:0]     i_d_addr;
   logic [DATA_W-1:0]     i_d_wdata;
   logic [DATA_W/8-1:0]   i_d_be;
   logic                  o_d_gnt;
   logic                  o_d_rvalid;
   logic [DATA_W-1:0]     o_d_rdata;
   logic                  o_mem_en;
   logic                  o_mem_we;
   logic [ADDR_W-1:0]     o_mem_addr;
   logic [DATA_W-1:0]     o_mem_wdata;
   logic [DATA_W/8-1:0]   o_mem_be;
   logic [DATA_W-1:0]     i_mem_rdata;
   logic                  o_stall;

   modport slave (
      input  i_if_req, i_if_addr, i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_be,
             i_mem_rdata,
      output o_if_gnt, o_if_rvalid, o_if_rdata, o_d_gnt, o_d_rvalid, o_d_rdata,
             o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be, o_stall
   );

   modport master (
      output i_if_req, i_if_addr, i_d_req, i_d_we, i_d_addr, i_d_wdata, i_d_be,
             i_mem_rdata,
      input  o_if_gnt, o_if_rvalid, o_if_rdata, o_d_gnt, o_d_rvalid, o_d_rdata,
             o_mem_en, o_mem_we, o_mem_addr, o_mem_wdata, o_mem_be, o_stall
   );
endinterface
`default_nettype wire

// File: rtl/klp32_mem_arbiter_rr_pick.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | klp32_rr_pick : 2-way tie picker, fixed data priority or round-robin  |
// | Rev 1.0                                                               |
// +----------------------------------------------------------------------+
module klp32_rr_pick
   import klp32_mem_pkg::*;
(
   input  wire logic   i_req_if,
   input  wire logic   i_req_d,
   input  wire owner_t i_last_owner,
   input  wire logic   i_data_prio,
   output logic [1:0]  o_gnt          // [0] = IF, [1] = D
);
   logic w_tie;
   logic w_d_wins;

   assign w_tie    = i_req_if & i_req_d;
   assign w_d_wins = i_data_prio | (i_last_owner == OWN_IF);

   always_comb begin
      o_gnt = {i_req_d, i_req_if};
      if (w_tie) begin
         o_gnt = w_d_wins ? 2'b10 : 2'b01;
      end
   end
endmodule
`default_nettype wire

// File: rtl/klp32_mem_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | klp32_mem_arbiter : shares one single-port memory between fetch and   |
// | load/store ports, one outstanding read at a time. Rev 1.0             |
// +----------------------------------------------------------------------+
module klp32_mem_arbiter
   import klp32_mem_pkg::*;
#(
   parameter int ADDR_W        = DEF_ADDR_W,
   parameter int DATA_W        = DEF_DATA_W,
   parameter int MEM_LAT       = 1,
   parameter int DATA_PRIORITY = 1
)(
   input wire logic           clk,
   input wire logic           reset,
   klp32_mem_arbiter_if.slave bus
);
   localparam int c_LAT   = (MEM_LAT > MEM_LAT_MAX) ? MEM_LAT_MAX :
                            (MEM_LAT < 1) ? 1 : MEM_LAT;
   localparam int c_CNT_W = $clog2(c_LAT + 1);
   localparam int c_BE_W  = DATA_W / 8;

   state_t               r_state, w_state_nxt;
   owner_t               r_owner, w_owner_nxt;
   owner_t               r_last_owner, w_last_nxt;
   logic [c_CNT_W-1:0]   r_lat_cnt, w_lat_nxt;

   logic [1:0]           w_pick;
   logic                 w_resp;
   logic                 w_can_grant;
   logic                 w_gnt_if;
   logic                 w_gnt_d;
   logic                 w_gnt;
   logic                 w_gnt_rd;
   logic                 w_rv_if;
   logic                 w_rv_d;

   klp32_rr_pick u_pick (
      .i_req_if     (bus.i_if_req),
      .i_req_d      (bus.i_d_req),
      .i_last_owner (r_last_owner),
      .i_data_prio  (DATA_PRIORITY != 0),
      .o_gnt        (w_pick)
   );

   // The response cycle doubles as a grant slot so reads pipeline back-to-back.
   assign w_resp      = (r_state == WAIT) && (r_lat_cnt == c_CNT_W'(1));
   assign w_can_grant = ~reset & ((r_state == IDLE) | w_resp);
   assign w_gnt_if    = w_can_grant & w_pick[0];
   assign w_gnt_d     = w_can_grant & w_pick[1];
   assign w_gnt       = w_gnt_if | w_gnt_d;
   assign w_gnt_rd    = w_gnt_if | (w_gnt_d & ~bus.i_d_we);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state      <= IDLE;
         r_owner      <= OWN_IF;
         r_last_owner <= OWN_D;
         r_lat_cnt    <= '0;
      end else begin
         r_state      <= w_state_nxt;
         r_owner      <= w_owner_nxt;
         r_last_owner <= w_last_nxt;
         r_lat_cnt    <= w_lat_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_owner_nxt = r_owner;
      w_last_nxt  = r_last_owner;
      w_lat_nxt   = r_lat_cnt;
      case (r_state)
         IDLE: w_lat_nxt = '0;
         WAIT: begin
            w_lat_nxt = r_lat_cnt - c_CNT_W'(1);
            if (w_resp) begin
               w_state_nxt = IDLE;
            end
         end
         default: w_state_nxt = IDLE;
      endcase
      if (w_gnt) begin
         w_last_nxt = w_gnt_d ? OWN_D : OWN_IF;
         if (w_gnt_rd) begin
            w_state_nxt = WAIT;
            w_owner_nxt = w_gnt_d ? OWN_D : OWN_IF;
            w_lat_nxt   = c_CNT_W'(c_LAT);
         end
      end
   end

   always_comb begin
      bus.o_mem_en    = w_gnt;
      bus.o_mem_we    = w_gnt_d & bus.i_d_we;
      bus.o_mem_addr  = '0;
      bus.o_mem_wdata = '0;
      bus.o_mem_be    = '0;
      if (w_gnt_d) begin
         bus.o_mem_addr  = bus.i_d_addr;
         bus.o_mem_wdata = bus.i_d_wdata;
         bus.o_mem_be    = bus.i_d_be;
      end else if (w_gnt_if) begin
         bus.o_mem_addr  = bus.i_if_addr;
         bus.o_mem_be    = {c_BE_W{1'b1}};
      end
   end

   assign w_rv_if = w_resp & (r_owner == OWN_IF);
   assign w_rv_d  = w_resp & (r_owner == OWN_D);

   assign bus.o_if_gnt    = w_gnt_if;
   assign bus.o_d_gnt     = w_gnt_d;
   assign bus.o_if_rvalid = w_rv_if;
   assign bus.o_d_rvalid  = w_rv_d;
   assign bus.o_if_rdata  = w_rv_if ? bus.i_mem_rdata : '0;
   assign bus.o_d_rdata   = w_rv_d  ? bus.i_mem_rdata : '0;

   assign bus.o_stall = ~reset & ((bus.i_if_req & ~w_gnt_if) |
                                  (bus.i_d_req  & ~w_gnt_d)  |
                                  ((r_state == WAIT) & ~w_resp));
endmodule
`default_nettype wire

// File: tb/tb_klp32_mem_arbiter.sv
`default_nettype none
`timescale 1ns/1ps
// +----------------------------------------------------------------------+
// | tb_klp32_mem_arbiter : four arbiter configurations against a cycle    |
// | timeline model plus hand-computed checks. Rev 1.0                     |
// +----------------------------------------------------------------------+
module tb_klp32_mem_arbiter;
   localparam int N = 4;

   function automatic int lat_of(input int k);
      case (k)
         2:       return 3;
         3:       return 2;
         default: return 1;
      endcase
   endfunction

   function automatic int dp_of(input int k);
      return (k == 1) ? 0 : 1;
   endfunction

   function automatic logic [31:0] init_word(input int i);
      return (i == 0) ? 32'h0050_0513 : (32'hC0DE_0000 | 32'(i));
   endfunction

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic [N-1:0]        rst;
   logic [N-1:0]        if_req, d_req, d_we;
   logic [N-1:0][31:0]  if_addr, d_addr, d_wdata;
   logic [N-1:0][3:0]   d_be;
   logic [N-1:0]        if_gnt, if_rvalid, d_gnt, d_rvalid, mem_en, mem_we, stall;
   logic [N-1:0][31:0]  if_rdata, d_rdata, mem_addr, mem_wdata;
   logic [N-1:0][3:0]   mem_be;

   int n_tests = 0;
   int n_fail  = 0;

   task automatic check(input string name, input int k, input logic [31:0] act,
                        input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s dut%0d t=%0t got 0x%08h expected 0x%08h", name, k, $time, act, exp);
      end
   endtask

   for (genvar k = 0; k < N; k++) begin : g_dut
      localparam int L  = lat_of(k);
      localparam int DP = dp_of(k);

      klp32_mem_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

      assign bus.i_if_req  = if_req[k];
      assign bus.i_if_addr = if_addr[k];
      assign bus.i_d_req   = d_req[k];
      assign bus.i_d_we    = d_we[k];
      assign bus.i_d_addr  = d_addr[k];
      assign bus.i_d_wdata = d_wdata[k];
      assign bus.i_d_be    = d_be[k];
      assign if_gnt[k]     = bus.o_if_gnt;
      assign if_rvalid[k]  = bus.o_if_rvalid;
      assign if_rdata[k]   = bus.o_if_rdata;
      assign d_gnt[k]      = bus.o_d_gnt;
      assign d_rvalid[k]   = bus.o_d_rvalid;
      assign d_rdata[k]    = bus.o_d_rdata;
      assign mem_en[k]     = bus.o_mem_en;
      assign mem_we[k]     = bus.o_mem_we;
      assign mem_addr[k]   = bus.o_mem_addr;
      assign mem_wdata[k]  = bus.o_mem_wdata;
      assign mem_be[k]     = bus.o_mem_be;
      assign stall[k]      = bus.o_stall;

      klp32_mem_arbiter #(
         .ADDR_W(32), .DATA_W(32), .MEM_LAT(L), .DATA_PRIORITY(DP)
      ) u_dut (
         .clk   (clk),
         .reset (rst[k]),
         .bus   (bus)
      );

      // Memory: read data appears exactly L cycles after the read strobe; never reset.
      logic [31:0] mem  [128];
      logic [31:0] pipe [L];
      assign bus.i_mem_rdata = pipe[L-1];

      initial begin
         for (int i = 0; i < 128; i++) mem[i] = init_word(i);
         for (int i = 0; i < L; i++) pipe[i] = 32'hDEAD_BEEF;
      end

      always @(posedge clk) begin
         for (int j = L - 1; j > 0; j--) pipe[j] <= pipe[j-1];
         pipe[0] <= 32'hDEAD_BEEF;
         if (bus.o_mem_en) begin
            if (bus.o_mem_we) begin
               for (int b = 0; b < 4; b++)
                  if (bus.o_mem_be[b]) mem[bus.o_mem_addr[8:2]][8*b +: 8] <= bus.o_mem_wdata[8*b +: 8];
            end else begin
               pipe[0] <= mem[bus.o_mem_addr[8:2]];
            end
         end
      end

      // Timeline model: a pending read returns at cycle resp_at.
      logic [31:0] ref_mem [128];
      int          cyc     = 0;
      bit          pend    = 1'b0;
      int          resp_at = 0;
      bit          pend_d  = 1'b0;
      logic [31:0] pend_data;
      bit          last_d  = 1'b1;

      initial for (int i = 0; i < 128; i++) ref_mem[i] = init_word(i);

      always @(negedge clk) begin
         bit          resp, avail, g_if, g_d;
         logic [31:0] e_addr, e_wdata, e_word;
         logic [3:0]  e_be;
         if (rst[k]) begin
            check("m_rst_if_gnt", k, if_gnt[k], 0);
            check("m_rst_d_gnt", k, d_gnt[k], 0);
            check("m_rst_rvalid", k, {if_rvalid[k], d_rvalid[k]}, 0);
            check("m_rst_mem", k, {mem_en[k], mem_we[k]}, 0);
            check("m_rst_stall", k, stall[k], 0);
            pend   = 1'b0;
            last_d = 1'b1;
         end else begin
            resp  = pend && (cyc == resp_at);
            avail = !pend || resp;
            g_if  = 1'b0;
            g_d   = 1'b0;
            if (avail) begin
               if (if_req[k] && d_req[k]) begin
                  g_d  = (DP != 0) || !last_d;
                  g_if = !g_d;
               end else begin
                  g_if = if_req[k];
                  g_d  = d_req[k];
               end
            end
            e_addr  = g_d ? d_addr[k] : (g_if ? if_addr[k] : 32'h0);
            e_wdata = g_d ? d_wdata[k] : 32'h0;
            e_be    = g_d ? d_be[k] : (g_if ? 4'hF : 4'h0);
            check("m_if_gnt", k, if_gnt[k], g_if);
            check("m_d_gnt", k, d_gnt[k], g_d);
            check("m_mem_en", k, mem_en[k], g_if | g_d);
            check("m_mem_we", k, mem_we[k], g_d & d_we[k]);
            check("m_mem_addr", k, mem_addr[k], e_addr);
            check("m_mem_wdata", k, mem_wdata[k], e_wdata);
            check("m_mem_be", k, mem_be[k], e_be);
            check("m_stall", k, stall[k],
                  (if_req[k] & !g_if) | (d_req[k] & !g_d) | (pend & !resp));
            check("m_if_rvalid", k, if_rvalid[k], resp & !pend_d);
            check("m_d_rvalid", k, d_rvalid[k], resp & pend_d);
            if (resp) begin
               check("m_rdata_owner", k, pend_d ? d_rdata[k] : if_rdata[k], pend_data);
               check("m_rdata_other", k, pend_d ? if_rdata[k] : d_rdata[k], 0);
            end
            if (resp) pend = 1'b0;
            if (g_if || g_d) begin
               last_d = g_d;
               if (g_if || !d_we[k]) begin
                  pend      = 1'b1;
                  resp_at   = cyc + L;
                  pend_d    = g_d;
                  pend_data = ref_mem[e_addr[8:2]];
               end else begin
                  e_word = ref_mem[e_addr[8:2]];
                  for (int b = 0; b < 4; b++)
                     if (e_be[b]) e_word[8*b +: 8] = e_wdata[8*b +: 8];
                  ref_mem[e_addr[8:2]] = e_word;
               end
            end
         end
         cyc++;
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_if(input int k, input bit req, input logic [31:0] a);
      if_req[k]  = req;
      if_addr[k] = a;
   endtask

   task automatic drive_d(input int k, input bit req, input bit we, input logic [31:0] a,
                          input logic [31:0] wd, input logic [3:0] be);
      d_req[k]   = req;
      d_we[k]    = we;
      d_addr[k]  = a;
      d_wdata[k] = wd;
      d_be[k]    = be;
   endtask

   initial begin
      rst = '1;
      if_req = '0; d_req = '0; d_we = '0;
      if_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0;

      // Reset holds off a pending fetch request
      step();
      drive_if(0, 1, 32'h0);
      @(negedge clk);
      check("rst_if_gnt", 0, if_gnt[0], 0);
      check("rst_stall", 0, stall[0], 0);
      check("rst_mem_en", 0, mem_en[0], 0);

      // Lone fetch, MEM_LAT=1
      step(); rst = '0;
      @(negedge clk);
      check("t1_if_gnt", 0, if_gnt[0], 1);
      step(); drive_if(0, 0, 32'h0);
      @(negedge clk);
      check("t1_if_rvalid", 0, if_rvalid[0], 1);
      check("t1_if_rdata", 0, if_rdata[0], 32'h0050_0513);
      check("t1_stall", 0, stall[0], 0);

      // Tie with data priority
      step(); drive_if(0, 1, 32'h4); drive_d(0, 1, 0, 32'h100, 0, 4'hF);
      @(negedge clk);
      check("t2_d_gnt", 0, d_gnt[0], 1);
      check("t2_if_gnt", 0, if_gnt[0], 0);
      check("t2_stall", 0, stall[0], 1);
      step(); drive_d(0, 0, 0, 32'h0, 0, 4'h0);
      @(negedge clk);
      check("t2_d_rvalid", 0, d_rvalid[0], 1);
      check("t2_d_rdata", 0, d_rdata[0], 32'hC0DE_0040);
      check("t2_if_gnt_late", 0, if_gnt[0], 1);
      check("t2_stall_clear", 0, stall[0], 0);
      step(); drive_if(0, 0, 32'h0);
      @(negedge clk);
      check("t2_if_rdata", 0, if_rdata[0], 32'hC0DE_0001);

      // Round-robin alternation
      step(); drive_if(1, 1, 32'h8); drive_d(1, 1, 0, 32'h10, 0, 4'hF);
      for (int c = 0; c < 6; c++) begin
         @(negedge clk);
         check("t3_if_gnt", 1, if_gnt[1], (c % 2) == 0);
         check("t3_d_gnt", 1, d_gnt[1], (c % 2) == 1);
         step();
      end
      drive_if(1, 0, 32'h0); drive_d(1, 0, 0, 32'h0, 0, 4'h0);
      step();

      // Write then read, MEM_LAT=3
      drive_d(2, 1, 1, 32'h100, 32'h4, 4'hF);
      @(negedge clk);
      check("t4_wr_gnt", 2, d_gnt[2], 1);
      check("t4_wr_we", 2, mem_we[2], 1);
      check("t4_wr_stall", 2, stall[2], 0);
      step(); drive_d(2, 1, 0, 32'h100, 32'h0, 4'hF);
      @(negedge clk);
      check("t4_rd_gnt", 2, d_gnt[2], 1);
      check("t4_rd_we", 2, mem_we[2], 0);
      step(); drive_d(2, 0, 0, 32'h0, 0, 4'h0); drive_if(2, 1, 32'hC);
      for (int c = 0; c < 2; c++) begin
         @(negedge clk);
         check("t4_wait_if_gnt", 2, if_gnt[2], 0);
         check("t4_wait_rvalid", 2, d_rvalid[2], 0);
         check("t4_wait_stall", 2, stall[2], 1);
         step();
      end
      @(negedge clk);
      check("t4_d_rvalid", 2, d_rvalid[2], 1);
      check("t4_d_rdata", 2, d_rdata[2], 32'h0000_0004);
      check("t4_if_gnt", 2, if_gnt[2], 1);
      step(); drive_if(2, 0, 32'h0);
      repeat (4) step();

      // Reset mid-read, MEM_LAT=2
      drive_if(3, 1, 32'h20);
      @(negedge clk);
      check("t5_if_gnt", 3, if_gnt[3], 1);
      step(); drive_if(3, 0, 32'h0); rst[3] = 1'b1;
      @(negedge clk);
      check("t5_rst_stall", 3, stall[3], 0);
      step(); rst[3] = 1'b0;
      @(negedge clk);
      check("t5_no_if_rvalid", 3, if_rvalid[3], 0);
      check("t5_no_d_rvalid", 3, d_rvalid[3], 0);
      step(); drive_if(3, 1, 32'h24);
      @(negedge clk);
      check("t5_regrant", 3, if_gnt[3], 1);
      step(); drive_if(3, 0, 32'h0);
      step();
      @(negedge clk);
      check("t5_if_rdata", 3, if_rdata[3], 32'hC0DE_0009);

      // Back-to-back writes then a read-back
      for (int i = 0; i < 4; i++) begin
         step(); drive_d(0, 1, 1, 32'h40 + 32'(4 * i), 32'h11 * 32'(i + 1), 4'hF);
         @(negedge clk);
         check("t6_d_gnt", 0, d_gnt[0], 1);
         check("t6_mem_we", 0, mem_we[0], 1);
         check("t6_stall", 0, stall[0], 0);
      end
      step(); drive_d(0, 1, 0, 32'h44, 32'h0, 4'hF);
      step(); drive_d(0, 0, 0, 32'h0, 32'h0, 4'h0);
      @(negedge clk);
      check("t6_readback", 0, d_rdata[0], 32'h0000_0022);

      repeat (3) step();
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/klp32_mem_arbiter.md
Name: klp32_mem_arbiter

Overview:
Shares one single-port synchronous memory between the KLP32 instruction-fetch port and the load/store data port.
- Arbitrates each cycle and holds one outstanding read at a time.
- Returns read data to the granted owner after a fixed latency.
- Raises a stall to the core whenever a requester is waiting.
- Enables moving the KLP32 core from split instruction/data memories to a unified memory.

Parameters:
ADDR_W, 32, address width of both ports and memory.
DATA_W, 32, data width; byte-enable width is DATA_W/8.
MEM_LAT, 1, memory read latency in cycles, legal 1..4.
DATA_PRIORITY, 1, 1 = data port always wins ties; 0 = round-robin on ties.

Ports:
clk  in  1  system clock, rising edge.
reset  in  1  asynchronous, active-high reset.
i_if_req  in  1  fetch read request.
i_if_addr  in  ADDR_W  fetch address.
o_if_gnt  out  1  fetch request accepted this cycle.
o_if_rvalid  out  1  fetch read data valid.
o_if_rdata  out  DATA_W  fetch read data.
i_d_req  in  1  data request.
i_d_we  in  1  1 = write, 0 = read.
i_d_addr  in  ADDR_W  data address.
i_d_wdata  in  DATA_W  write data.
i_d_be  in  DATA_W/8  write byte enables.
o_d_gnt  out  1  data request accepted this cycle.
o_d_rvalid  out  1  data read data valid.
o_d_rdata  out  DATA_W  data read data.
o_mem_en  out  1  memory access strobe.
o_mem_we  out  1  memory write enable.
o_mem_addr  out  ADDR_W  memory address.
o_mem_wdata  out  DATA_W  memory write data.
o_mem_be  out  DATA_W/8  memory byte enables.
i_mem_rdata  in  DATA_W  memory read data, valid MEM_LAT cycles after a read strobe.
o_stall  out  1  core must hold its pipeline.

Behaviour:
- States: IDLE, WAIT. Registers: state, owner (IF/D), lat_cnt of width $clog2(MEM_LAT+1), last_owner.
- Grant is combinational and happens only in IDLE, or in the WAIT cycle where lat_cnt==1 (the cycle the response returns), so reads issue back-to-back every MEM_LAT cycles.
- Tie resolution (both requesting):
  - DATA_PRIORITY=1: D wins.
  - DATA_PRIORITY=0: the port not equal to last_owner wins.
  - last_owner updates on every grant.
- On grant:
  - o_mem_en=1; mem address/we/wdata/be are muxed from the winner.
  - IF grants always drive we=0 and be=all-ones.
- Read grant: next state WAIT, owner=winner, lat_cnt=MEM_LAT.
- Write grant: completes in the grant cycle, no rvalid, state stays/returns IDLE; writes may grant every cycle.
- In WAIT, lat_cnt decrements each cycle. When lat_cnt==1:
  - the owner's rvalid=1 that cycle;
  - the owner's rdata = i_mem_rdata (combinational pass-through);
  - next state is IDLE unless a new read is granted in the same cycle.
- With MEM_LAT=1, rvalid asserts the cycle after the grant.
- rdata of a non-owner port = 0. rvalid is never asserted on both ports in one cycle.
- Requester contract: req, addr, we, wdata and be stay stable from assertion until gnt. req may drop the cycle after gnt. Violations are undefined.
- Outputs when no grant: o_mem_en=0, o_mem_we=0; addr/wdata/be are don't-care and drive 0.
- o_stall = (i_if_req & ~o_if_gnt) | (i_d_req & ~o_d_gnt) | (state==WAIT & lat_cnt!=1).
- Starvation: possible for IF only when DATA_PRIORITY=1 with continuous data requests. Round-robin mode bounds the wait to one transaction.
- Reset (asynchronous, any cycle including mid-read):
  - state=IDLE, lat_cnt=0, owner=IF, last_owner=D, so IF wins the first RR tie.
  - All gnt, rvalid, mem_en, mem_we and stall outputs are 0 while reset is high.
  - An in-flight response arriving after reset deasserts is discarded (no rvalid).

Decomposition:
- Package klp32_mem_pkg holds:
  - state_t enum {IDLE, WAIT};
  - owner_t enum {OWN_IF, OWN_D};
  - MEM_LAT_MAX=4;
  - default ADDR_W/DATA_W constants.
- One sub-module, klp32_rr_pick: the 2-way tie picker. Inputs: two reqs, last_owner, priority mode. Outputs: one-hot grant. Purely combinational.
- The FSM, latency counter and muxing stay in the top module.

Test Plan:
- Reset, then IF read 0x0000_0000 alone, MEM_LAT=1, memory returns 0x0050_0513 -> if_gnt in cycle 0; if_rvalid=1 and if_rdata=0x0050_0513 in cycle 1; stall=0 in cycle 1.
- Simultaneous IF read 0x4 and D read 0x100, DATA_PRIORITY=1 -> d_gnt first, d_rvalid next cycle; if_gnt on the same cycle as d_rvalid; stall high until if_gnt.
- DATA_PRIORITY=0, both requesting continuously for 6 grants -> grants alternate IF, D, IF, D, IF, D.
- D write 0x100 data 0x4 be=0xF, then D read 0x100, MEM_LAT=3 -> write: mem_we=1 for one cycle, no rvalid. Read: granted the next cycle, d_rvalid exactly 3 cycles later with data 0x4, no grants in between.
- MEM_LAT=2 read granted, reset pulsed 1 cycle later, memory still drives data -> no rvalid on either port; state IDLE; next IF request granted immediately.
- Back-to-back D writes on 4 consecutive cycles -> 4 consecutive d_gnt and mem_we pulses, stall=0 throughout.
